// File: rtl/ldpc_cnu_serial_if.sv
// Handshake bundle between a variable-node source, the serial check-node
// unit and the downstream VPU lanes. The master modport is the side that
// drives messages in and accepts results. The slave modport is the CNU.
interface ldpc_cnu_serial_if #(
    parameter int LLR_WIDTH = 8,
    parameter int IDX_WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [LLR_WIDTH-1:0] in_llr;
    logic                 out_valid;
    logic                 out_ready;
    logic [LLR_WIDTH-1:0] out_llr;
    logic [IDX_WIDTH-1:0] out_idx;
    logic                 out_last;

    modport master (
        output in_valid, in_llr, out_ready,
        input  in_ready, out_valid, out_llr, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_llr, out_ready,
        output in_ready, out_valid, out_llr, out_idx, out_last
    );
endinterface

// File: rtl/ldpc_cnu_serial.sv
// Serial offset min-sum check-node unit. Each frame has ROW_WEIGHT
// variable-to-check LLRs. An accumulator bank tracks min1/min2/min_idx and
// the signs while a frame streams in. A separate output bank replays the
// previous frame as ROW_WEIGHT check-to-variable messages, so consecutive
// rows overlap without bubbles. A completed frame that cannot move to a busy
// output bank is parked in the accumulator (HOLD) with input stalled.
module ldpc_cnu_serial #(
    parameter int ROW_WEIGHT = 24,
    parameter int LLR_WIDTH  = 8,
    parameter int OFFSET     = 1,
    parameter int IDX_WIDTH  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    ldpc_cnu_serial_if.slave  bus
);
    localparam logic [LLR_WIDTH-1:0] MAG_MAX  = {1'b0, {(LLR_WIDTH-1){1'b1}}};
    localparam logic [LLR_WIDTH-1:0] MOST_NEG = {1'b1, {(LLR_WIDTH-1){1'b0}}};
    localparam logic [LLR_WIDTH-1:0] OFF_V    = LLR_WIDTH'(OFFSET);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(ROW_WEIGHT - 1);

    typedef enum logic {ST_ACC, ST_HOLD} acc_state_t;

    acc_state_t r_state;
    acc_state_t w_state_next;

    // accumulator bank
    logic [IDX_WIDTH-1:0]  r_count;
    logic [LLR_WIDTH-1:0]  r_min1;
    logic [LLR_WIDTH-1:0]  r_min2;
    logic [IDX_WIDTH-1:0]  r_min_idx;
    logic                  r_sign_acc;
    logic [ROW_WEIGHT-1:0] r_signs;

    // output bank
    logic                  r_bank_valid;
    logic [IDX_WIDTH-1:0]  r_out_idx;
    logic [LLR_WIDTH-1:0]  r_b_min1;
    logic [LLR_WIDTH-1:0]  r_b_min2;
    logic [IDX_WIDTH-1:0]  r_b_min_idx;
    logic                  r_b_sign_acc;
    logic [ROW_WEIGHT-1:0] r_b_signs;

    // accumulator values including the message being accepted this cycle
    logic                  w_accept;
    logic                  w_sign;
    logic [LLR_WIDTH-1:0]  w_mag;
    logic [LLR_WIDTH-1:0]  w_upd_min1;
    logic [LLR_WIDTH-1:0]  w_upd_min2;
    logic [IDX_WIDTH-1:0]  w_upd_min_idx;
    logic                  w_upd_sign_acc;
    logic [ROW_WEIGHT-1:0] w_upd_signs;

    // frame hand-over between banks
    logic                  w_frame_done;
    logic                  w_out_fire;
    logic                  w_out_last;
    logic                  w_bank_free;
    logic                  w_load;
    logic                  w_acc_clear;
    logic [LLR_WIDTH-1:0]  w_src_min1;
    logic [LLR_WIDTH-1:0]  w_src_min2;
    logic [IDX_WIDTH-1:0]  w_src_min_idx;
    logic                  w_src_sign_acc;
    logic [ROW_WEIGHT-1:0] w_src_signs;

    // output datapath
    logic                  w_sel_sign;
    logic                  w_out_sign;
    logic [LLR_WIDTH-1:0]  w_m;
    logic [LLR_WIDTH-1:0]  w_m_off;

    assign bus.in_ready = (r_state == ST_ACC);
    assign w_accept     = bus.in_valid & (r_state == ST_ACC);
    assign w_sign       = bus.in_llr[LLR_WIDTH-1];
    // the most negative code has no positive twin, so clamp it
    assign w_mag        = (bus.in_llr == MOST_NEG) ? MAG_MAX :
                          (w_sign ? -bus.in_llr : bus.in_llr);

    // strict compare keeps the earliest index on ties; an equal value lands in min2
    always_comb begin
        w_upd_min1     = r_min1;
        w_upd_min2     = r_min2;
        w_upd_min_idx  = r_min_idx;
        w_upd_sign_acc = r_sign_acc ^ w_sign;
        if (w_mag < r_min1) begin
            w_upd_min2    = r_min1;
            w_upd_min1    = w_mag;
            w_upd_min_idx = r_count;
        end else if (w_mag < r_min2) begin
            w_upd_min2 = w_mag;
        end
    end

    // sign of the incoming message lands at the current row position
    generate
        for (genvar gi = 0; gi < ROW_WEIGHT; gi++) begin : g_sign_store
            assign w_upd_signs[gi] = (r_count == IDX_WIDTH'(gi)) ? w_sign : r_signs[gi];
        end
    endgenerate

    assign w_frame_done = w_accept & (r_count == LAST_IDX);
    assign w_out_fire   = r_bank_valid & bus.out_ready;
    assign w_out_last   = r_bank_valid & (r_out_idx == LAST_IDX);
    assign w_bank_free  = ~r_bank_valid | (w_out_fire & w_out_last);

    // a parked frame already sits in the accumulator registers; otherwise the
    // frame includes the message completing it this cycle
    assign w_src_min1     = (r_state == ST_HOLD) ? r_min1     : w_upd_min1;
    assign w_src_min2     = (r_state == ST_HOLD) ? r_min2     : w_upd_min2;
    assign w_src_min_idx  = (r_state == ST_HOLD) ? r_min_idx  : w_upd_min_idx;
    assign w_src_sign_acc = (r_state == ST_HOLD) ? r_sign_acc : w_upd_sign_acc;
    assign w_src_signs    = (r_state == ST_HOLD) ? r_signs    : w_upd_signs;

    // accumulator state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next state plus bank transfer / accumulator clear strobes
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_acc_clear  = 1'b0;
        case (r_state)
            ST_ACC: begin
                if (w_frame_done) begin
                    if (w_bank_free) begin
                        w_load      = 1'b1;
                        w_acc_clear = 1'b1;
                    end else begin
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_bank_free) begin
                    w_load       = 1'b1;
                    w_acc_clear  = 1'b1;
                    w_state_next = ST_ACC;
                end
            end
            default: w_state_next = ST_ACC;
        endcase
    end

    // accumulator: fold in each accepted message, restart after a hand-over
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_min1     <= MAG_MAX;
            r_min2     <= MAG_MAX;
            r_min_idx  <= '0;
            r_sign_acc <= 1'b0;
            r_signs    <= '0;
        end else if (w_acc_clear) begin
            r_count    <= '0;
            r_min1     <= MAG_MAX;
            r_min2     <= MAG_MAX;
            r_min_idx  <= '0;
            r_sign_acc <= 1'b0;
            r_signs    <= '0;
        end else if (w_accept) begin
            r_count    <= (r_count == LAST_IDX) ? '0 : r_count + 1'b1;
            r_min1     <= w_upd_min1;
            r_min2     <= w_upd_min2;
            r_min_idx  <= w_upd_min_idx;
            r_sign_acc <= w_upd_sign_acc;
            r_signs    <= w_upd_signs;
        end
    end

    // output bank: a load wins over retiring the last beat so frames chain with no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_valid <= 1'b0;
            r_out_idx    <= '0;
            r_b_min1     <= '0;
            r_b_min2     <= '0;
            r_b_min_idx  <= '0;
            r_b_sign_acc <= 1'b0;
            r_b_signs    <= '0;
        end else if (w_load) begin
            r_bank_valid <= 1'b1;
            r_out_idx    <= '0;
            r_b_min1     <= w_src_min1;
            r_b_min2     <= w_src_min2;
            r_b_min_idx  <= w_src_min_idx;
            r_b_sign_acc <= w_src_sign_acc;
            r_b_signs    <= w_src_signs;
        end else if (w_out_fire) begin
            if (w_out_last) begin
                r_bank_valid <= 1'b0;
                r_out_idx    <= '0;
            end else begin
                r_out_idx <= r_out_idx + 1'b1;
            end
        end
    end

    // pick the stored sign of the position being emitted
    always_comb begin
        w_sel_sign = 1'b0;
        for (int k = 0; k < ROW_WEIGHT; k++) begin
            if (r_out_idx == IDX_WIDTH'(k)) begin
                w_sel_sign = r_b_signs[k];
            end
        end
    end

    // extrinsic magnitude minus offset (floored at zero), then apply the extrinsic sign
    always_comb begin
        w_m        = (r_out_idx == r_b_min_idx) ? r_b_min2 : r_b_min1;
        w_m_off    = (w_m > OFF_V) ? (w_m - OFF_V) : '0;
        w_out_sign = r_b_sign_acc ^ w_sel_sign;
    end

    assign bus.out_llr   = w_out_sign ? -w_m_off : w_m_off;
    assign bus.out_valid = r_bank_valid;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = w_out_last;

endmodule

// File: tb/tb_ldpc_cnu_serial.sv
// Bench for the serial check-node unit (ROW_WEIGHT=4, OFFSET=1). A frame
// model computes each row's outputs from global minima and sign parity. One
// compare process checks every output handshake against it and checks
// stability under stall. Directed frames are also pinned to hand-computed literals.
module tb_ldpc_cnu_serial;
    localparam int RW  = 4;
    localparam int LW  = 8;
    localparam int IW  = 5;
    localparam int OFF = 1;

    typedef struct {
        int llr;
        int idx;
        int last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ldpc_cnu_serial_if #(.LLR_WIDTH(LW), .IDX_WIDTH(IW)) bus ();

    ldpc_cnu_serial #(
        .ROW_WEIGHT(RW),
        .LLR_WIDTH (LW),
        .OFFSET    (OFF),
        .IDX_WIDTH (IW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   part[$];
    exp_t exp_q[$];
    int   got_q[$];
    int   n_beats = 0;
    int   n_last = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    // expected outputs of one row from its inputs
    function automatic void model_frame();
        int mag[RW];
        int m1, m2, i1, par, m, mp, s;
        exp_t e;
        m1 = 1 << 30; m2 = 1 << 30; i1 = 0; par = 0;
        for (int j = 0; j < RW; j++) begin
            mag[j] = (part[j] == -(1 << (LW-1))) ? (1 << (LW-1)) - 1 :
                     (part[j] < 0 ? -part[j] : part[j]);
            if (part[j] < 0) par ^= 1;
        end
        for (int j = 0; j < RW; j++) if (mag[j] < m1) begin m1 = mag[j]; i1 = j; end
        for (int j = 0; j < RW; j++) if (j != i1 && mag[j] < m2) m2 = mag[j];
        for (int j = 0; j < RW; j++) begin
            m  = (j == i1) ? m2 : m1;
            mp = (m > OFF) ? m - OFF : 0;
            s  = par ^ ((part[j] < 0) ? 1 : 0);
            e.llr  = s ? -mp : mp;
            e.idx  = j;
            e.last = (j == RW-1) ? 1 : 0;
            exp_q.push_back(e);
        end
    endfunction

    // single compare process: tracks accepted inputs, checks each output beat
    logic            stall = 1'b0;
    logic [LW-1:0]   prev_llr;
    logic [IW-1:0]   prev_idx;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            part.delete();
            exp_q.delete();
            stall = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                part.push_back(int'($signed(bus.in_llr)));
                if (part.size() == RW) begin
                    model_frame();
                    part.delete();
                end
            end
            if (stall) begin
                chk("stall_valid", int'(bus.out_valid), 1);
                chk("stall_llr", int'(bus.out_llr), int'(prev_llr));
                chk("stall_idx", int'(bus.out_idx), int'(prev_idx));
            end
            if (bus.out_valid && bus.out_ready) begin
                n_beats++;
                if (bus.out_last) n_last++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got llr %0d, expected no output", $signed(bus.out_llr));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_llr", int'($signed(bus.out_llr)), e.llr);
                    chk("out_idx", int'(bus.out_idx), e.idx);
                    chk("out_last", int'(bus.out_last), e.last);
                end
                got_q.push_back(int'($signed(bus.out_llr)));
            end
            stall    = bus.out_valid && !bus.out_ready;
            prev_llr = bus.out_llr;
            prev_idx = bus.out_idx;
        end
    end

    // present one message and hold until accepted; returns at posedge+1
    task automatic send(input int v);
        bit acc;
        int t;
        bus.in_valid = 1'b1;
        bus.in_llr   = v[LW-1:0];
        acc = 1'b0;
        t   = 0;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        if (!acc) fail("send");
    endtask

    task automatic send_frame(input int v[RW], input bit gaps);
        for (int j = 0; j < RW; j++) begin
            send(v[j]);
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_frame(input string name, input int e[RW]);
        int t = 0;
        while (got_q.size() < RW && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (got_q.size() < RW) fail(name);
        else for (int j = 0; j < RW; j++) chk(name, got_q[j], e[j]);
        got_q.delete();
    endtask

    initial begin
        int basic[RW];
        int tie[RW];
        int zro[RW];
        int rv[RW];
        int t;
        bit rnd_done;
        basic = '{5, -3, 7, -128};
        tie   = '{4, -4, 6, 9};
        zro   = '{1, 1, 0, 2};

        bus.in_valid  = 1'b0;
        bus.in_llr    = '0;
        bus.out_ready = 1'b1;

        // reset values
        #12;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_llr", int'(bus.out_llr), 0);
        chk("rst_out_idx", int'(bus.out_idx), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic frame with one-cycle latency check on the last input
        got_q.delete();
        for (int j = 0; j < RW-1; j++) send(basic[j]);
        bus.in_llr = basic[RW-1][LW-1:0];
        @(negedge clk);
        chk("lat_pre_valid", int'(bus.out_valid), 0);
        chk("lat_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("lat_valid", int'(bus.out_valid), 1);
        chk("lat_idx0", int'(bus.out_idx), 0);
        chk_frame("basic", '{2, -4, 2, -2});

        send_frame(tie, 1'b0);
        chk_frame("tie", '{-3, 3, -3, -3});
        send_frame(zro, 1'b0);
        chk_frame("zero_clamp", '{0, 0, 0, 0});

        // backpressure: second frame parks in HOLD, third frame's input refused
        got_q.delete();
        bus.out_ready = 1'b0;
        send_frame(basic, 1'b0);
        send_frame(tie, 1'b0);
        chk("hold_in_ready", int'(bus.in_ready), 0);
        chk("hold_out_idx", int'(bus.out_idx), 0);
        chk("hold_out_llr", int'($signed(bus.out_llr)), 2);
        bus.in_valid = 1'b1;
        bus.in_llr   = 8'd33;
        repeat (3) begin
            @(negedge clk);
            chk("third_refused", int'(bus.in_ready), 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2*RW; k++) begin
            @(negedge clk);
            chk("nobubble_valid", int'(bus.out_valid), 1);
            chk("seq_idx", int'(bus.out_idx), k % RW);
            if (k == RW-1) chk("ready_in_hold", int'(bus.in_ready), 0);
            if (k == RW)   chk("ready_after_xfer", int'(bus.in_ready), 1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("drained_valid", int'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        if (got_q.size() != 2*RW) fail("bp_beats");
        else begin
            chk("bp_frame1", got_q[0], 2);  chk("bp_frame1", got_q[1], -4);
            chk("bp_frame1", got_q[2], 2);  chk("bp_frame1", got_q[3], -2);
            chk("bp_frame2", got_q[4], -3); chk("bp_frame2", got_q[5], 3);
            chk("bp_frame2", got_q[6], -3); chk("bp_frame2", got_q[7], -3);
        end
        got_q.delete();

        // reset while one frame is emitting and another is half received
        bus.out_ready = 1'b0;
        send_frame(basic, 1'b0);
        send(1);
        send(2);
        bus.in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(bus.out_valid), 0);
        chk("arst_in_ready", int'(bus.in_ready), 1);
        chk("arst_out_idx", int'(bus.out_idx), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send_frame(basic, 1'b0);
        chk_frame("post_reset", '{2, -4, 2, -2});

        // random frames with input gaps and output backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    for (int j = 0; j < RW; j++) begin
                        rv[j] = int'($urandom_range(0, 255));
                        if (rv[j] > 127) rv[j] -= 256;
                        if ($urandom_range(0, 7) == 0) rv[j] = -128;
                    end
                    send_frame(rv, 1'b1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        t = 0;
        while ((exp_q.size() != 0 || part.size() != 0) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0 || part.size() != 0) fail("drain");
        chk("last_per_frame", n_last * RW, n_beats);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1, "watchdog");
    end
endmodule
